// File: rtl/ula_pkg.sv
// Shared constants for the operand entry stage and the ALU decode.
package ula_pkg;

   localparam int DIGIT_MAX = 9;
   localparam int OP_W      = 2;
   localparam int KEY_N     = 3;

   localparam logic [OP_W-1:0] OP_ADD = 2'd0;
   localparam logic [OP_W-1:0] OP_SUB = 2'd1;
   localparam logic [OP_W-1:0] OP_MUL = 2'd2;
   localparam logic [OP_W-1:0] OP_DIV = 2'd3;

   // KEY bit positions
   localparam int KEY_OP = 0;
   localparam int KEY_B  = 1;
   localparam int KEY_A  = 2;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop sync, hold-time debounce, registered press pulse on a
// stable 1->0 transition (active-low key, so a press is the falling edge).
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic key,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             stable;
   logic             stable_d;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= key;
         sync_2 <= sync_1;
      end
   end

   // Any return to the accepted level restarts the hold interval, so a glitch
   // shorter than DEBOUNCE_CYCLES never reaches stable.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         stable <= 1'b1;
         count  <= '0;
      end else if (sync_2 == stable) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         stable <= sync_2;
         count  <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         stable_d <= 1'b1;
         press    <= 1'b0;
      end else begin
         stable_d <= stable;
         press    <= stable_d & ~stable;
      end
   end

endmodule

// File: rtl/operand_entry.sv
// Operand/opcode entry: three debounced keys step operands a, b (0..DIGIT_MAX)
// and opcode op (mod 4); upd marks the first cycle a new value is visible.
module operand_entry #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int DIGIT_MAX       = ula_pkg::DIGIT_MAX,
   parameter int OPND_W          = 8
) (
   input  logic                     CLOCK_50,
   input  logic                     RESET_N,
   input  logic [2:0]               KEY,
   output logic [OPND_W-1:0]        a,
   output logic [OPND_W-1:0]        b,
   output logic [ula_pkg::OP_W-1:0] op,
   output logic                     upd
);

   import ula_pkg::*;

   logic [KEY_N-1:0] press;

   for (genvar i = 0; i < KEY_N; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debounce (
         .clk_sys (CLOCK_50),
         .rst_n   (RESET_N),
         .key     (KEY[i]),
         .press   (press[i])
      );
   end

   // >= rather than == so a corrupted register falls back to 0 on the next press
   function automatic logic [OPND_W-1:0] next_digit(input logic [OPND_W-1:0] v);
      return (v >= OPND_W'(DIGIT_MAX)) ? '0 : v + 1'b1;
   endfunction

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         a   <= '0;
         b   <= '0;
         op  <= OP_ADD;
         upd <= 1'b0;
      end else begin
         if (press[KEY_A]) a <= next_digit(a);
         if (press[KEY_B]) b <= next_digit(b);
         if (press[KEY_OP]) op <= op + 1'b1;
         upd <= |press;
      end
   end

endmodule
